inject_arbiter: RTL and testbench
=================================

// Module: inject_arbiter
// PURPOSE
//  Per-PE injection scheduler in front of the router's client port.
//  Shares the single injection port among N_CLIENTS requesters.
//  Each client has its own token-bucket regulator (MAX_RATE, MAX_TOKEN).
//  A round-robin arbiter picks among eligible clients into a 1-entry output register.
// PARAMETERS
//  N_CLIENTS  4   number of requesters (>=2)
//  MAX_RATE   10  replenish period in cycles, i.e. 1/injection rate (>=1)
//  MAX_TOKEN  5   bucket depth = max back-to-back flits per client (>=1)
//  DATA_W     32  flit payload width
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  async reset, active-high
//  req_valid  in   N_CLIENTS          client i has a flit pending
//  req_data   in   N_CLIENTS*DATA_W   client i flit at [i*DATA_W +: DATA_W]
//  req_ack    out  N_CLIENTS          one-hot, combinational; flit i taken this cycle
//  out_valid  out  1                  output register holds a flit
//  out_data   out  DATA_W             flit toward router injection port
//  out_ready  in   1                  router accepts flit this cycle (no deflection)
// BEHAVIOUR
//  Reset (async assert, sync deassert at clk):
//   - out_valid=0, out_data=0, req_ack=0
//   - all cnt[i]=MAX_TOKEN, per[i]=0, rr_ptr=0
//  Regulator per client i:
//   - per[i] counts 0..MAX_RATE-1 every cycle, free-running; wraps to 0 after MAX_RATE-1
//   - rep[i]=(per[i]==MAX_RATE-1); cons[i]=req_ack[i]
//   - Next cnt: rep&!cons -> cnt+1, saturating at MAX_TOKEN
//   - !rep&cons -> cnt-1
//   - rep&cons or neither -> unchanged
//   - cnt width $clog2(MAX_TOKEN+1); must never underflow or exceed MAX_TOKEN
//   - MAX_RATE=1: rep every cycle, so unlimited rate
//  Arbitration:
//   - elig[i]=req_valid[i] & (cnt[i]!=0)
//   - load=!out_valid | out_ready
//   - When load & |elig: grant first eligible i scanning rr_ptr, rr_ptr+1, ... mod N_CLIENTS
//   - req_ack[i]=1 for the granted client only; all 0 when !load or no eligible
//   - On grant: out_data<=req_data[i], out_valid<=1, rr_ptr<=(i+1) mod N_CLIENTS
//   - load & no grant: out_valid<=0 (out_data don't-care, holds)
//   - !load: output register holds; rr_ptr holds
//  Latency / throughput:
//   - ack at cycle t -> out_valid at t+1
//   - Full throughput (1 flit/cycle) while out_ready=1
//  Handshake rules:
//   - Client must hold req_valid/req_data until acked
//   - Dropping req_valid before ack is allowed; the flit is simply not taken
//   - Ineligible client (cnt=0) is skipped, not blocked on; the next eligible client wins
//  Stalls: out_ready=0 with out_valid=1 -> no acks, no cnt consumption; buckets keep refilling
//  Reset mid-operation: buffered flit dropped, buckets refilled to MAX_TOKEN
// TESTING
//  1. Single client 0, req_valid=1 always, out_ready=1, defaults:
//     - acks at cycles 0,1,2,3,4,10,20,...,90 after reset release
//     - 14 acks in cycles 0..99
//  2. All 4 clients valid, out_ready=1:
//     - grants 0,1,2,3,0,1,... round-robin
//     - each client gets 5 acks in the first 20 cycles
//     - after that, <=1 ack per client per 10 cycles
//  3. out_ready=0 for 30 cycles with flit held:
//     - out_valid/out_data stable, req_ack=0
//     - on release, each bucket at MAX_TOKEN, never above
//  4. Client 1 cnt=0 while clients 1 and 2 valid, rr_ptr=1:
//     - client 2 granted same cycle; no stall cycle
//  5. Replenish and consume in the same cycle (per=9, cnt=2):
//     - cnt stays 2
//     - at cnt=5 with per=9 and no consume, cnt stays 5
//  6. Assert rst mid-burst with out_valid=1:
//     - out_valid=0 immediately (async)
//     - after release, 5-flit burst available again per client

Source files
------------

// File: rtl/inject_arbiter.sv
// inject_arbiter
//   Per-PE injection scheduler in front of the router's client port. Each of
//   N_CLIENTS requesters owns a token bucket that refills one token every
//   MAX_RATE cycles and holds at most MAX_TOKEN tokens. A round-robin arbiter
//   picks one eligible requester (flit pending and token available) per cycle
//   into a single-entry output register.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active-high
//   req_valid  per-client flit pending
//   req_data   per-client flit, client i at [i*DATA_W +: DATA_W]
//   req_ack    one-hot combinational ack; flit i taken this cycle
//   out_valid  output register holds a flit
//   out_data   flit toward the router injection port
//   out_ready  router accepts the held flit this cycle
module inject_arbiter #(
    parameter int unsigned N_CLIENTS = 4,
    parameter int unsigned MAX_RATE  = 10,
    parameter int unsigned MAX_TOKEN = 5,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CLIENTS-1:0]        req_valid,
    input  logic [N_CLIENTS*DATA_W-1:0] req_data,
    output logic [N_CLIENTS-1:0]        req_ack,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        out_ready
);

    localparam int unsigned CntW = $clog2(MAX_TOKEN + 1);
    localparam int unsigned PerW = (MAX_RATE > 1) ? $clog2(MAX_RATE) : 1;
    localparam int unsigned PtrW = $clog2(N_CLIENTS);

    localparam logic [CntW-1:0] TokenMax = CntW'(MAX_TOKEN);
    localparam logic [PerW-1:0] PerLast  = PerW'(MAX_RATE - 1);
    localparam logic [PtrW-1:0] PtrLast  = PtrW'(N_CLIENTS - 1);

    logic [CntW-1:0]      cnt_q [N_CLIENTS];
    logic [CntW-1:0]      cnt_d [N_CLIENTS];
    logic [PerW-1:0]      per_q [N_CLIENTS];
    logic [PerW-1:0]      per_d [N_CLIENTS];
    logic [PtrW-1:0]      rr_q;
    logic [PtrW-1:0]      rr_d;
    logic                 out_valid_q;
    logic [DATA_W-1:0]    out_data_q;

    logic [N_CLIENTS-1:0] elig;
    logic [N_CLIENTS-1:0] grant;
    logic                 grant_any;
    logic [PtrW-1:0]      grant_idx;
    logic [DATA_W-1:0]    grant_data;
    logic                 load;

    // Round-robin pick starting at rr_q. Acks are suppressed while reset is
    // asserted so no client believes its flit was taken by a register that
    // is being cleared.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        load       = !out_valid_q || out_ready;
        grant      = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            elig[i] = req_valid[i] && (cnt_q[i] != '0);
        end
        if (load && !rst) begin
            for (int k = 0; k < N_CLIENTS; k++) begin
                idx = (int'(rr_q) + k) % N_CLIENTS;
                if (!grant_any && elig[idx]) begin
                    grant[idx] = 1'b1;
                    grant_any  = 1'b1;
                    grant_idx  = PtrW'(idx);
                    grant_data = req_data[idx*DATA_W +: DATA_W];
                end
            end
        end
        rr_d = (grant_idx == PtrLast) ? '0 : grant_idx + 1'b1;
    end

    // Token buckets. A replenish and a consume in the same cycle cancel, so
    // a full bucket that is drawn on at the refill point stays full.
    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            logic rep;
            rep      = (per_q[i] == PerLast);
            per_d[i] = rep ? '0 : per_q[i] + 1'b1;
            cnt_d[i] = cnt_q[i];
            if (rep && !grant[i]) begin
                if (cnt_q[i] != TokenMax) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (!rep && grant[i]) begin
                // grant implies cnt_q != 0, so this cannot underflow
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rr_q        <= '0;
            for (int i = 0; i < N_CLIENTS; i++) begin
                cnt_q[i] <= TokenMax;
                per_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                cnt_q[i] <= cnt_d[i];
                per_q[i] <= per_d[i];
            end
            if (load) begin
                out_valid_q <= grant_any;
                if (grant_any) begin
                    out_data_q <= grant_data;
                    rr_q       <= rr_d;
                end
            end
        end
    end

    assign req_ack   = grant;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_inject_arbiter.sv
// tb_inject_arbiter
//   Directed bench for inject_arbiter with default parameters. A driver issues
//   per-cycle stimulus and pushes the expected flit into a scoreboard queue;
//   a monitor pops and compares whenever the router side takes a flit.
module tb_inject_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ack;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;

    inject_arbiter #(
        .N_CLIENTS(N),
        .MAX_RATE (10),
        .MAX_TOKEN(5),
        .DATA_W   (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ack  (req_ack),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] sb_q[$];
    logic [3:0]  ack_log[256];
    int          cyc;
    int          seq[N];

    // Reference token-bucket / round-robin behaviour
    int m_cnt[N];
    int m_per;
    int m_rr;
    bit m_ov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 5;
        m_per = 0;
        m_rr  = 0;
        m_ov  = 1'b0;
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input bit rdy);
        int i;
        if (m_ov && !rdy) return -1;
        for (int k = 0; k < N; k++) begin
            i = (m_rr + k) % N;
            if (v[i] && m_cnt[i] != 0) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int g, input bit rdy);
        bit load;
        bit rep;
        load = !m_ov || rdy;
        rep  = (m_per == 9);
        for (int i = 0; i < N; i++) begin
            if (rep && g != i) begin
                if (m_cnt[i] < 5) m_cnt[i]++;
            end else if (!rep && g == i) begin
                m_cnt[i]--;
            end
        end
        m_per = rep ? 0 : m_per + 1;
        if (load) begin
            m_ov = (g >= 0);
            if (g >= 0) m_rr = (g + 1) % N;
        end
        if (g >= 0) seq[g]++;
    endtask

    // One clock cycle: called at #1 after a rising edge, returns at the same
    // point of the next cycle.
    task automatic run_cycle(input logic [N-1:0] v, input bit rdy);
        int         g;
        logic [3:0] exp_ack;
        req_valid = v;
        out_ready = rdy;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
        g       = model_grant(v, rdy);
        exp_ack = (g >= 0) ? 4'(1 << g) : 4'b0000;
        if (g >= 0) sb_q.push_back({8'(g), 24'(seq[g])});
        @(negedge clk);
        chk("req_ack", {28'd0, req_ack}, {28'd0, exp_ack});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        if (cyc < 256) ack_log[cyc] = req_ack;
        model_step(g, rdy);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        model_reset();
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_req_ack", {28'd0, req_ack}, 32'd0);
        rst = 1'b0;
        cyc = 0;
        for (int t = 0; t < 256; t++) ack_log[t] = 4'b0000;
    endtask

    function automatic int acks_of(input int c, input int a, input int b);
        int n = 0;
        for (int t = a; t <= b; t++) if (ack_log[t][c]) n++;
        return n;
    endfunction

    // Scoreboard monitor: a flit leaves whenever out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow: got flit %0h expected none at t=%0t",
                         out_data, $time);
            end else begin
                chk("out_data", out_data, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 0;
        req_data = '0;

        // 1: single client, acks at 0..4 then every 10th cycle
        do_reset();
        for (int t = 0; t < 100; t++) run_cycle(4'b0001, 1'b1);
        for (int t = 0; t < 100; t++)
            chk("t1_ack_cycle", {31'd0, ack_log[t][0]}, {31'd0, (t < 5) || (t % 10 == 0)});
        chk("t1_ack_count", 32'(acks_of(0, 0, 99)), 32'd14);

        // 2: all clients, strict rotation while buckets last
        do_reset();
        for (int t = 0; t < 100; t++) run_cycle(4'b1111, 1'b1);
        for (int t = 0; t < 20; t++)
            chk("t2_rr_order", {28'd0, ack_log[t]}, {28'd0, 4'(1 << (t % 4))});
        for (int c = 0; c < N; c++) chk("t2_first20", 32'(acks_of(c, 0, 19)), 32'd5);
        for (int w = 50; w < 100; w += 10)
            for (int c = 0; c < N; c++)
                chk("t2_rate_limit", {31'd0, acks_of(c, w, w + 9) <= 1}, 32'd1);

        // 3: long stall with a held flit, then a fresh full burst
        do_reset();
        for (int t = 0; t < 3; t++) run_cycle(4'b1111, 1'b1);
        for (int t = 0; t < 30; t++) begin
            run_cycle(4'b1111, 1'b0);
            chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_hold_data", out_data, (sb_q.size() > 0) ? sb_q[0] : 32'hdead_beef);
        end
        while (cyc % 10 != 0) run_cycle(4'b1111, 1'b0);
        for (int t = 0; t < 9; t++) run_cycle(4'b0001, 1'b1);
        chk("t3_stall_acks", 32'(acks_of(0, 3, cyc - 10)), 32'd0);
        chk("t3_burst", 32'(acks_of(0, cyc - 9, cyc - 1)), 32'd5);

        // 4: empty bucket at rr_ptr is skipped without a bubble
        do_reset();
        for (int t = 0; t < 5; t++) run_cycle(4'b0010, 1'b1);
        run_cycle(4'b0001, 1'b1);
        run_cycle(4'b0110, 1'b1);
        chk("t4_drain", 32'(acks_of(1, 0, 4)), 32'd5);
        chk("t4_skip", {28'd0, ack_log[6]}, 32'h4);
        run_cycle(4'b0000, 1'b1);

        // 5a: refill and consume together keep cnt at 2
        do_reset();
        for (int t = 0; t < 3; t++) run_cycle(4'b0001, 1'b1);
        for (int t = 3; t < 9; t++) run_cycle(4'b0000, 1'b1);
        run_cycle(4'b0001, 1'b1);
        for (int t = 10; t < 19; t++) run_cycle(4'b0001, 1'b1);
        chk("t5_same_cycle_ack", {28'd0, ack_log[9]}, 32'h1);
        chk("t5_cnt_two", 32'(acks_of(0, 10, 18)), 32'd2);

        // 5b: full bucket does not overflow at the refill point
        do_reset();
        for (int t = 0; t < 10; t++) run_cycle(4'b0000, 1'b1);
        for (int t = 10; t < 19; t++) run_cycle(4'b0001, 1'b1);
        chk("t5_saturate", 32'(acks_of(0, 10, 18)), 32'd5);

        // 6: asynchronous reset mid-burst
        do_reset();
        for (int t = 0; t < 3; t++) run_cycle(4'b1111, 1'b1);
        chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_async_data", out_data, 32'd0);
        chk("t6_async_ack", {28'd0, req_ack}, 32'd0);
        do_reset();
        for (int t = 0; t < 9; t++) run_cycle(4'b0010, 1'b1);
        chk("t6_burst_front", 32'(acks_of(1, 0, 4)), 32'd5);
        chk("t6_burst_total", 32'(acks_of(1, 0, 8)), 32'd5);

        // drain the output register
        for (int t = 0; t < 2; t++) run_cycle(4'b0000, 1'b1);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
